// File: rtl/memory_request_credit_scheduler.sv
// Round-robin memory request scheduler with per-requester burst hold,
// outstanding-credit limits and an enable/drain sequencer.
module memory_request_credit_scheduler #(
    parameter int NUM_MEMORY_REQUESTOR = 4,
    parameter int PAYLOAD_WIDTH        = 64,
    parameter int MAX_OUTSTANDING      = 8,
    parameter int ID_WIDTH             = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
    parameter int CNT_WIDTH            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                          ap_clk,
    input  logic                                          areset,
    input  logic                                          cfg_enable_in,
    input  logic [CNT_WIDTH-1:0]                          cfg_credit_limit_in,
    input  logic [3:0]                                    cfg_burst_in,
    input  logic [NUM_MEMORY_REQUESTOR-1:0]               req_valid_in,
    input  logic [NUM_MEMORY_REQUESTOR*PAYLOAD_WIDTH-1:0] req_payload_in,
    output logic [NUM_MEMORY_REQUESTOR-1:0]               req_ready_out,
    output logic                                          mem_valid_out,
    output logic [PAYLOAD_WIDTH-1:0]                      mem_payload_out,
    output logic [ID_WIDTH-1:0]                           mem_id_out,
    input  logic                                          mem_ready_in,
    input  logic                                          rsp_valid_in,
    input  logic [ID_WIDTH-1:0]                           rsp_id_in,
    output logic                                          idle_out,
    output logic                                          credit_error_out
);

    localparam int          N  = NUM_MEMORY_REQUESTOR;
    localparam int unsigned NU = N;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   limit_q, limit_d;
    logic [3:0]             burst_q, burst_d;
    logic [CNT_WIDTH-1:0]   count_q [N];
    logic [CNT_WIDTH-1:0]   count_d [N];
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [ID_WIDTH-1:0]    rr_q, rr_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic                   mem_valid_q, mem_valid_d;
    logic [PAYLOAD_WIDTH-1:0] mem_payload_q, mem_payload_d;
    logic [ID_WIDTH-1:0]    mem_id_q, mem_id_d;
    logic                   err_q, err_d;

    logic [N-1:0]           eligible;
    logic                   burst_active;
    logic                   slot_free;
    logic                   grant_vld;
    logic [ID_WIDTH-1:0]    grant_id;
    logic [ID_WIDTH-1:0]    cand;
    logic [31:0]            base;
    logic                   accept;
    logic                   rsp_ok, rsp_err;
    logic                   all_zero_d;
    logic [3:0]             nb;

    always_comb begin
        for (int unsigned i = 0; i < NU; i++) begin
            eligible[i] = req_valid_in[i] && (count_q[i] < limit_q);
        end
    end

    assign burst_active = (bcnt_q != 4'd0);
    assign slot_free    = !mem_valid_q || mem_ready_in;

    // An active burst always has bcnt < burst (it clears on reaching burst), so
    // rotating from the owner grants it first when still eligible, and otherwise
    // behaves as a search from owner+1.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        base      = burst_active ? 32'(owner_q) : 32'(rr_q);
        for (int unsigned k = 0; k < NU; k++) begin
            cand = ID_WIDTH'((base + k) % NU);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign accept = (state_q == S_ARB) && slot_free && grant_vld;

    always_comb begin
        req_ready_out = '0;
        if (accept) req_ready_out[grant_id] = 1'b1;
    end

    always_comb begin
        rsp_ok  = 1'b0;
        rsp_err = 1'b0;
        if (rsp_valid_in) begin
            if ((int'(rsp_id_in) < N) && (count_q[rsp_id_in] != '0)) rsp_ok  = 1'b1;
            else                                                      rsp_err = 1'b1;
        end
        all_zero_d = 1'b1;
        for (int unsigned i = 0; i < NU; i++) begin
            count_d[i] = count_q[i];
            if (accept && (grant_id == ID_WIDTH'(i)) && !(rsp_ok && (rsp_id_in == ID_WIDTH'(i))))
                count_d[i] = count_q[i] + CNT_WIDTH'(1);
            else if (rsp_ok && (rsp_id_in == ID_WIDTH'(i)) && !(accept && (grant_id == ID_WIDTH'(i))))
                count_d[i] = count_q[i] - CNT_WIDTH'(1);
            if (count_d[i] != '0) all_zero_d = 1'b0;
        end
        err_d = err_q | rsp_err;
    end

    always_comb begin
        owner_d       = owner_q;
        rr_d          = rr_q;
        bcnt_d        = bcnt_q;
        nb            = 4'd1;
        mem_valid_d   = mem_valid_q;
        mem_payload_d = mem_payload_q;
        mem_id_d      = mem_id_q;
        if (accept) begin
            nb      = (burst_active && (grant_id == owner_q)) ? bcnt_q + 4'd1 : 4'd1;
            owner_d = grant_id;
            if (nb >= burst_q) begin
                rr_d   = (grant_id == ID_WIDTH'(N - 1)) ? '0 : grant_id + ID_WIDTH'(1);
                bcnt_d = 4'd0;
            end else begin
                bcnt_d = nb;
            end
            mem_valid_d   = 1'b1;
            mem_payload_d = req_payload_in[32'(grant_id)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            mem_id_d      = grant_id;
        end else if (mem_ready_in) begin
            mem_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        burst_d = burst_q;
        unique case (state_q)
            S_IDLE: if (cfg_enable_in) begin
                state_d = S_ARB;
                limit_d = ((cfg_credit_limit_in == '0) ||
                           (cfg_credit_limit_in > CNT_WIDTH'(MAX_OUTSTANDING)))
                          ? CNT_WIDTH'(MAX_OUTSTANDING) : cfg_credit_limit_in;
                burst_d = (cfg_burst_in == 4'd0) ? 4'd1 : cfg_burst_in;
            end
            S_ARB:   if (!cfg_enable_in) state_d = S_DRAIN;
            S_DRAIN: begin
                if (cfg_enable_in)                    state_d = S_ARB;
                else if (!mem_valid_d && all_zero_d)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q       <= S_IDLE;
            limit_q       <= '0;
            burst_q       <= 4'd1;
            owner_q       <= '0;
            rr_q          <= '0;
            bcnt_q        <= 4'd0;
            mem_valid_q   <= 1'b0;
            mem_payload_q <= '0;
            mem_id_q      <= '0;
            err_q         <= 1'b0;
            for (int unsigned i = 0; i < NU; i++) count_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            limit_q       <= limit_d;
            burst_q       <= burst_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            bcnt_q        <= bcnt_d;
            mem_valid_q   <= mem_valid_d;
            mem_payload_q <= mem_payload_d;
            mem_id_q      <= mem_id_d;
            err_q         <= err_d;
            for (int unsigned i = 0; i < NU; i++) count_q[i] <= count_d[i];
        end
    end

    assign mem_valid_out    = mem_valid_q;
    assign mem_payload_out  = mem_payload_q;
    assign mem_id_out       = mem_id_q;
    assign idle_out         = (state_q == S_IDLE);
    assign credit_error_out = err_q;

endmodule

// File: tb/tb_memory_request_credit_scheduler.sv
// Bench for memory_request_credit_scheduler: directed scenarios plus random
// traffic, checked every cycle against a transaction-level scheduler model.
module tb_memory_request_credit_scheduler;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk;
    logic           areset;
    logic           en;
    logic [3:0]     lim_cfg;
    logic [3:0]     bur_cfg;
    logic [N-1:0]   rv;
    logic [N*W-1:0] pay;
    logic [N-1:0]   rdy;
    logic           mv;
    logic [W-1:0]   mpay;
    logic [1:0]     mid;
    logic           mrdy;
    logic           rspv;
    logic [1:0]     rspid;
    logic           idle;
    logic           err;

    memory_request_credit_scheduler #(
        .NUM_MEMORY_REQUESTOR(N),
        .PAYLOAD_WIDTH(W),
        .MAX_OUTSTANDING(8)
    ) dut (
        .ap_clk(clk), .areset(areset), .cfg_enable_in(en),
        .cfg_credit_limit_in(lim_cfg), .cfg_burst_in(bur_cfg),
        .req_valid_in(rv), .req_payload_in(pay), .req_ready_out(rdy),
        .mem_valid_out(mv), .mem_payload_out(mpay), .mem_id_out(mid),
        .mem_ready_in(mrdy), .rsp_valid_in(rspv), .rsp_id_in(rspid),
        .idle_out(idle), .credit_error_out(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 idle, 1 running, 2 draining.
    int          m_phase;
    int          m_lim, m_bur;
    int          m_out [N];
    int          m_owner, m_run, m_next;
    bit          m_mv;
    logic [W-1:0] m_pay;
    int          m_id;
    bit          m_err;

    bit cap;
    int grants[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_lim = 0; m_bur = 1;
        foreach (m_out[i]) m_out[i] = 0;
        m_owner = 0; m_run = 0; m_next = 0;
        m_mv = 0; m_pay = '0; m_id = 0; m_err = 0;
    endtask

    // Requester that should be served this cycle, or -1.
    function automatic int pick();
        int start;
        if (m_phase != 1) return -1;
        if (m_mv && !mrdy) return -1;
        start = (m_run > 0) ? m_owner : m_next;
        for (int k = 0; k < N; k++) begin
            int r = (start + k) % N;
            if (rv[r] && m_out[r] < m_lim) return r;
        end
        return -1;
    endfunction

    task automatic model_clock(input int g);
        int  nout [N];
        bit  empty;
        foreach (m_out[i]) nout[i] = m_out[i];
        if (g >= 0) begin
            nout[g]++;
            if (m_run > 0 && g == m_owner) m_run++;
            else                           m_run = 1;
            m_owner = g;
            if (m_run >= m_bur) begin
                m_next = (g + 1) % N;
                m_run  = 0;
            end
        end
        if (rspv) begin
            if (m_out[rspid] > 0) nout[rspid]--;
            else                  m_err = 1;
        end
        if (g >= 0) begin
            m_mv = 1; m_pay = pay[g*W +: W]; m_id = g;
        end else if (mrdy) begin
            m_mv = 0;
        end
        empty = !m_mv;
        foreach (nout[i]) if (nout[i] != 0) empty = 0;
        case (m_phase)
            0: if (en) begin
                m_phase = 1;
                m_lim = (lim_cfg == 0 || lim_cfg > 8) ? 8 : int'(lim_cfg);
                m_bur = (bur_cfg == 0) ? 1 : int'(bur_cfg);
            end
            1: if (!en) m_phase = 2;
            default: if (en) m_phase = 1; else if (empty) m_phase = 0;
        endcase
        foreach (m_out[i]) m_out[i] = nout[i];
    endtask

    task automatic step();
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        g  = pick();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("ready", 64'(rdy), 64'(er));
        check("mem_valid", 64'(mv), 64'(m_mv));
        check("mem_payload", mpay, m_pay);
        check("mem_id", 64'(mid), 64'(m_id));
        check("idle", 64'(idle), 64'(m_phase == 0));
        check("credit_err", 64'(err), 64'(m_err));
        if (cap) for (int i = 0; i < N; i++) if (rdy[i]) grants.push_back(i);
        @(posedge clk);
        model_clock(g);
        #1;
    endtask

    task automatic rand_pay();
        for (int i = 0; i < N * W / 32; i++) pay[i*32 +: 32] = $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rand_pay();
            step();
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #1;
        check("rst_valid", 64'(mv), 64'd0);
        check("rst_payload", mpay, 64'd0);
        check("rst_id", 64'(mid), 64'd0);
        check("rst_ready", 64'(rdy), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        model_reset();
        @(posedge clk);
        #3;
        areset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held;
        int n;
        areset = 1'b1; en = 0; lim_cfg = 0; bur_cfg = 0; rv = '0; pay = '0;
        mrdy = 1; rspv = 0; rspid = 0; cap = 0;
        model_reset();
        do_reset();

        // Plain round robin, burst 1.
        lim_cfg = 8; bur_cfg = 1; rv = 4'hF; en = 1; cap = 1; grants.delete();
        run(12);
        cap = 0;
        check("rr_count", 64'(grants.size() >= 8), 64'd1);
        for (int k = 0; k < 8; k++) check("rr_seq", 64'(grants[k]), 64'(k % 4));

        // Burst of 3 between requesters 0 and 2.
        do_reset();
        en = 0; bur_cfg = 3; rv = 4'b0101;
        en = 1; cap = 1; grants.delete();
        run(10);
        cap = 0;
        begin
            int exp_b [9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
            for (int k = 0; k < 9; k++) check("burst_seq", 64'(grants[k]), 64'(exp_b[k]));
        end

        // Owner loses eligibility mid-burst.
        do_reset();
        cap = 1; grants.delete();
        run(3);
        rv = 4'b0100;
        run(2);
        cap = 0;
        check("burst_drop_len", 64'(grants.size()), 64'd4);
        check("burst_drop_sw", 64'(grants[2]), 64'd2);

        // Credit limit of 2 on requester 1.
        do_reset();
        lim_cfg = 2; bur_cfg = 1; rv = 4'b0010; cap = 1; grants.delete();
        run(6);
        check("limit_two", 64'(grants.size()), 64'd2);
        rspv = 1; rspid = 1; run(1); rspv = 0;
        run(3);
        check("limit_refill", 64'(grants.size()), 64'd3);
        rspv = 1; run(1);
        run(1);
        rspv = 0;
        run(3);
        cap = 0;

        // Downstream stall holds the output register.
        do_reset();
        lim_cfg = 8; rv = 4'b0001; mrdy = 1;
        run(2);
        mrdy = 0;
        held = mpay;
        for (int i = 0; i < 5; i++) begin
            rand_pay(); step();
            check("stall_hold", mpay, held);
            check("stall_noready", 64'(rdy), 64'd0);
        end
        mrdy = 1;
        run(3);

        // Drain with 3 outstanding on requester 0.
        do_reset();
        mrdy = 1; rv = 4'b0001;
        run(4);
        rv = '0; en = 0;
        run(2);
        rspv = 1; rspid = 0;
        run(2);
        check("drain_busy", 64'(idle), 64'd0);
        run(1);
        rspv = 0;
        check("drain_idle", 64'(idle), 64'd1);
        run(2);

        // Response to an empty requester is a sticky error.
        rspv = 1; rspid = 3; run(1); rspv = 0;
        run(3);
        check("err_sticky", 64'(err), 64'd1);

        // Random traffic with occasional drain requests.
        for (int round = 0; round < 3; round++) begin
            do_reset();
            lim_cfg = 4'($urandom_range(0, 15));
            bur_cfg = 4'($urandom_range(0, 15));
            en = 1;
            for (int c = 0; c < 300; c++) begin
                rv   = 4'($urandom);
                mrdy = ($urandom_range(0, 9) < 7);
                n    = $urandom_range(0, N - 1);
                rspv = ($urandom_range(0, 1) == 1) && (m_out[n] > 0 || $urandom_range(0, 40) == 0);
                rspid = 2'(n);
                if ($urandom_range(0, 60) == 0) en = ~en;
                rand_pay();
                step();
            end
            rspv = 0;
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        lim_cfg = 8; bur_cfg = 4; rv = 4'hF; mrdy = 1; en = 1;
        run(4);
        do_reset();
        run(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
